// File: rtl/flex_pts_serializer.sv
// Buffered parallel-to-serial transmitter: a small FIFO of {data, length} words feeds a shifter
// that emits one bit per shift_enable strobe, with no gap between back-to-back words.
module flex_pts_serializer #(
  parameter int unsigned NUM_BITS  = 8,
  parameter int unsigned DEPTH     = 2,
  parameter bit          SHIFT_MSB = 1'b1,
  parameter bit          IDLE_VAL  = 1'b0,
  localparam int unsigned LW       = $clog2(NUM_BITS + 1)
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [NUM_BITS-1:0] parallel_in,
  input  logic [LW-1:0]       load_len,
  input  logic                shift_enable,
  input  logic                flush,
  output logic                serial_out,
  output logic                busy,
  output logic                word_done,
  output logic [LW-1:0]       bits_left
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  typedef struct packed {
    logic [LW-1:0]       len;
    logic [NUM_BITS-1:0] data;
  } entry_t;

  entry_t              mem [DEPTH];
  state_t              state_q, state_d;
  logic [NUM_BITS-1:0] sr_q, sr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                serial_d, busy_d, done_d;
  logic [LW-1:0]       left_d;

  logic                empty, full, push, pop, last_bit;
  entry_t              head;
  logic [LW-1:0]       head_len;
  logic [NUM_BITS-1:0] aligned;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(DEPTH));
  assign load_ready = !full;

  assign push     = load_valid && !full && !flush;
  assign last_bit = (state_q == SHIFT) && shift_enable && (bits_left == LW'(1));
  assign pop      = !flush && !empty && ((state_q == IDLE) || last_bit);

  // Head word with its length normalised and, for MSB-first, bit L-1 moved to the top
  assign head     = mem[rd_ptr_q];
  assign head_len = ((head.len == '0) || (head.len > LW'(NUM_BITS))) ? LW'(NUM_BITS) : head.len;
  assign aligned  = SHIFT_MSB ? (head.data << (LW'(NUM_BITS) - head_len)) : head.data;

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    serial_d = serial_out;
    busy_d   = busy;
    left_d   = bits_left;
    done_d   = 1'b0;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (flush) begin
      state_d  = IDLE;
      sr_d     = '0;
      serial_d = IDLE_VAL;
      busy_d   = 1'b0;
      left_d   = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      done_d = last_bit;
      if (pop) begin
        state_d  = SHIFT;
        sr_d     = aligned;
        serial_d = SHIFT_MSB ? aligned[NUM_BITS-1] : aligned[0];
        busy_d   = 1'b1;
        left_d   = head_len;
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else if (last_bit) begin
        state_d  = IDLE;
        serial_d = IDLE_VAL;
        busy_d   = 1'b0;
        left_d   = '0;
      end else if ((state_q == SHIFT) && shift_enable) begin
        sr_d     = SHIFT_MSB ? (sr_q << 1) : (sr_q >> 1);
        serial_d = SHIFT_MSB ? sr_d[NUM_BITS-1] : sr_d[0];
        left_d   = bits_left - LW'(1);
      end

      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      serial_out <= IDLE_VAL;
      busy       <= 1'b0;
      word_done  <= 1'b0;
      bits_left  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      serial_out <= serial_d;
      busy       <= busy_d;
      word_done  <= done_d;
      bits_left  <= left_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the reset pointers and count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= '{len: load_len, data: parallel_in};
  end

endmodule

// File: tb/tb_flex_pts_serializer.sv
// Scoreboard bench: two serializers (MSB-first/IDLE 0 and LSB-first/IDLE 1) share stimulus;
// each accepted word queues its hand-written bit sequence per instance for the monitor.
module tb_flex_pts_serializer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       load_valid, shift_enable, flush;
  logic [7:0] parallel_in;
  logic [3:0] load_len;

  logic       so [2];
  logic       bsy [2];
  logic       wd [2];
  logic       lr [2];
  logic [3:0] bl [2];

  typedef struct {
    logic       b;
    logic [3:0] left;
    logic       last;
  } exp_t;

  exp_t q [2][$];
  logic pend [2];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  flex_pts_serializer #(.NUM_BITS(8), .DEPTH(2), .SHIFT_MSB(1'b1), .IDLE_VAL(1'b0)) u_msb (
    .clk(clk), .n_rst(n_rst), .load_valid(load_valid), .load_ready(lr[0]),
    .parallel_in(parallel_in), .load_len(load_len), .shift_enable(shift_enable), .flush(flush),
    .serial_out(so[0]), .busy(bsy[0]), .word_done(wd[0]), .bits_left(bl[0]));

  flex_pts_serializer #(.NUM_BITS(8), .DEPTH(2), .SHIFT_MSB(1'b0), .IDLE_VAL(1'b1)) u_lsb (
    .clk(clk), .n_rst(n_rst), .load_valid(load_valid), .load_ready(lr[1]),
    .parallel_in(parallel_in), .load_len(load_len), .shift_enable(shift_enable), .flush(flush),
    .serial_out(so[1]), .busy(bsy[1]), .word_done(wd[1]), .bits_left(bl[1]));

  function automatic logic idle_of(input int d);
    return (d == 1);
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0h want %0h at %0t", nm, d, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word; seq holds the transmitted bits in order, first bit leftmost
  task automatic push_word(input logic [7:0] data, input logic [3:0] len, input logic [7:0] mseq,
                           input logic [7:0] lseq, input int n, output int waits);
    exp_t e;
    waits       = 0;
    load_valid  = 1'b1;
    parallel_in = data;
    load_len    = len;
    while (!lr[0] && waits < 100) begin
      tick();
      waits++;
    end
    if (!lr[0]) begin
      chk("push_timeout", 0, 32'(lr[0]), 32'd1);
      load_valid = 1'b0;
      return;
    end
    for (int i = 0; i < n; i++) begin
      e.left = 4'(n - i);
      e.last = (i == n - 1);
      e.b    = mseq[n-1-i];
      q[0].push_back(e);
      e.b    = lseq[n-1-i];
      q[1].push_back(e);
    end
    tick();
    load_valid = 1'b0;
  endtask

  task automatic strobe_n(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      shift_enable = 1'b1;
      tick();
      shift_enable = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic wait_busy();
    int c = 0;
    while (!bsy[0] && c < 20) begin
      tick();
      c++;
    end
    chk("wait_busy", 0, 32'(bsy[0]), 32'd1);
  endtask

  // Monitor: the bit on serial_out is checked while busy and consumed on each strobe
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (!n_rst) begin
        q[d].delete();
        pend[d] = 1'b0;
      end else begin
        chk("word_done", d, 32'(wd[d]), 32'(pend[d]));
        pend[d] = 1'b0;
        if (bsy[d]) begin
          if (q[d].size() == 0) begin
            chk("bit_expected", d, 32'd0, 32'd1);
          end else begin
            e = q[d][0];
            chk("serial_out", d, 32'(so[d]), 32'(e.b));
            chk("bits_left", d, 32'(bl[d]), 32'(e.left));
            if (shift_enable && !flush) begin
              void'(q[d].pop_front());
              pend[d] = e.last;
            end
          end
        end else begin
          chk("idle_serial", d, 32'(so[d]), 32'(idle_of(d)));
          chk("idle_bits_left", d, 32'(bl[d]), 32'd0);
        end
        if (flush) q[d].delete();
      end
    end
  end

  initial begin
    int w;
    n_rst        = 1'b0;
    load_valid   = 1'b0;
    shift_enable = 1'b0;
    flush        = 1'b0;
    parallel_in  = '0;
    load_len     = '0;
    pend[0]      = 1'b0;
    pend[1]      = 1'b0;
    repeat (2) tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_serial", d, 32'(so[d]), 32'(idle_of(d)));
      chk("rst_busy", d, 32'(bsy[d]), 32'd0);
      chk("rst_ready", d, 32'(lr[d]), 32'd1);
      chk("rst_bits_left", d, 32'(bl[d]), 32'd0);
    end
    n_rst = 1'b1;
    tick();

    // A5, len 0 -> full width, one-cycle load latency, strobe every cycle
    push_word(8'hA5, 4'd0, 8'b10100101, 8'b10100101, 8, w);
    chk("latency_busy_n", 0, 32'(bsy[0]), 32'd0);
    tick();
    chk("latency_busy_n1", 0, 32'(bsy[0]), 32'd1);
    chk("latency_bits_left", 0, 32'(bl[0]), 32'd8);
    strobe_n(8, 0);
    tick();
    chk("a5_done_busy", 0, 32'(bsy[0]), 32'd0);

    // Same word with one strobe in three cycles
    push_word(8'hA5, 4'd0, 8'b10100101, 8'b10100101, 8, w);
    wait_busy();
    strobe_n(8, 2);
    repeat (2) tick();

    // Two short words back-to-back with no gap
    push_word(8'h0B, 4'd3, 8'b011, 8'b110, 3, w);
    push_word(8'hFF, 4'd2, 8'b11, 8'b11, 2, w);
    wait_busy();
    strobe_n(5, 0);
    repeat (2) tick();

    // Backpressure: shifter stalled, FIFO fills, 4th accept waits for the first pop
    push_word(8'h96, 4'd0, 8'b10010110, 8'b01101001, 8, w);
    push_word(8'h0B, 4'd3, 8'b011, 8'b110, 3, w);
    push_word(8'h02, 4'd1, 8'b0, 8'b0, 1, w);
    chk("full_ready", 0, 32'(lr[0]), 32'd0);
    chk("full_busy", 0, 32'(bsy[0]), 32'd1);
    chk("full_bits_left", 0, 32'(bl[0]), 32'd8);
    fork
      push_word(8'hFF, 4'd2, 8'b11, 8'b11, 2, w);
      strobe_n(14, 0);
    join
    chk("fourth_accept_wait", 0, 32'(w), 32'd8);
    repeat (2) tick();

    // Flush mid-word with one word queued, then a recovery word with len above NUM_BITS
    push_word(8'hC3, 4'd0, 8'b11000011, 8'b11000011, 8, w);
    push_word(8'h0F, 4'd4, 8'b1111, 8'b1111, 4, w);
    wait_busy();
    strobe_n(3, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("flush_busy", d, 32'(bsy[d]), 32'd0);
      chk("flush_done", d, 32'(wd[d]), 32'd0);
      chk("flush_ready", d, 32'(lr[d]), 32'd1);
      chk("flush_serial", d, 32'(so[d]), 32'(idle_of(d)));
    end
    tick();
    push_word(8'h96, 4'd12, 8'b10010110, 8'b01101001, 8, w);
    wait_busy();
    strobe_n(8, 0);
    repeat (2) tick();

    // Async reset with FIFO full and the shifter mid-word
    push_word(8'h96, 4'd0, 8'b10010110, 8'b01101001, 8, w);
    push_word(8'h0F, 4'd4, 8'b1111, 8'b1111, 4, w);
    push_word(8'hFF, 4'd2, 8'b11, 8'b11, 2, w);
    strobe_n(2, 0);
    chk("pre_rst_ready", 0, 32'(lr[0]), 32'd0);
    #2;
    n_rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("async_rst_serial", d, 32'(so[d]), 32'(idle_of(d)));
      chk("async_rst_busy", d, 32'(bsy[d]), 32'd0);
      chk("async_rst_done", d, 32'(wd[d]), 32'd0);
      chk("async_rst_bits_left", d, 32'(bl[d]), 32'd0);
      chk("async_rst_ready", d, 32'(lr[d]), 32'd1);
    end
    tick();
    n_rst = 1'b1;
    tick();
    push_word(8'h0B, 4'd3, 8'b011, 8'b110, 3, w);
    wait_busy();
    strobe_n(3, 0);
    repeat (3) tick();

    for (int d = 0; d < 2; d++) chk("queue_drained", d, 32'(q[d].size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
